// File: rtl/adder_result_accumulator_pkg.sv
// Shared definitions for the adder result accumulator.
// Contents:
//   DEF_IN_W / DEF_ACC_W / DEF_CNT_W - default widths, shared by the top and the bench
//   state_t                          - FSM state encoding (IDLE=0, ACCUM=1, DONE=2)
//   result_value()                   - packs the adder's {c_out, sum} into one value
package adder_result_accumulator_pkg;

  localparam int DEF_IN_W  = 3;
  localparam int DEF_ACC_W = 8;
  localparam int DEF_CNT_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // The carry out is the MSB of the adder result, so the value range is
  // 0 .. 2^(IN_W+1)-1 rather than 0 .. 2^IN_W-1.
  function automatic logic [DEF_IN_W:0] result_value(input logic cout,
                                                     input logic [DEF_IN_W-1:0] sum);
    return {cout, sum};
  endfunction

endpackage

// File: rtl/adder_result_accumulator_acc_adder_ext.sv
// acc_adder_ext: widened add of the running accumulator and one adder result.
// Ports:
//   acc_i   [ACC_W-1:0] current accumulator value
//   val_i   [IN_W:0]    adder result {c_out, sum}, zero-extended before adding
//   sum_o   [ACC_W-1:0] new accumulator value, modulo 2^ACC_W
//   carry_o             carry out of the ACC_W-bit add (feeds the sticky overflow)
module acc_adder_ext #(
  parameter int IN_W  = 3,
  parameter int ACC_W = 8
) (
  input  logic [ACC_W-1:0] acc_i,
  input  logic [IN_W:0]    val_i,
  output logic [ACC_W-1:0] sum_o,
  output logic             carry_o
);

  logic [ACC_W:0] full_sum;

  // One extra bit above the accumulator width captures the wrap-around carry.
  always_comb begin
    full_sum = {1'b0, acc_i} + {{(ACC_W - IN_W){1'b0}}, val_i};
  end

  assign sum_o   = full_sum[ACC_W-1:0];
  assign carry_o = full_sum[ACC_W];

endmodule

// File: rtl/adder_result_accumulator.sv
// adder_result_accumulator: sums a programmable number of ripple-adder results.
// Ports:
//   clk, rst_n              clock (rising edge), asynchronous active-low reset
//   start, num_samples      begin a run of num_samples results (honoured in IDLE only)
//   in_valid, in_sum,
//   in_cout, in_ready       input handshake carrying the adder's {c_out, sum}
//   out_valid, out_acc,
//   out_ovf, out_ready      output handshake carrying the total and sticky overflow
//   busy                    high while a run is in progress or its total is pending
module adder_result_accumulator
  import adder_result_accumulator_pkg::*;
#(
  parameter int IN_W  = DEF_IN_W,
  parameter int ACC_W = DEF_ACC_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] num_samples,
  input  logic             in_valid,
  input  logic [IN_W-1:0]  in_sum,
  input  logic             in_cout,
  output logic             in_ready,
  output logic             out_valid,
  output logic [ACC_W-1:0] out_acc,
  output logic             out_ovf,
  input  logic             out_ready,
  output logic             busy
);

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] n_lat_q, n_lat_d;
  logic             ovf_q, ovf_d;

  logic [ACC_W-1:0] add_sum;
  logic             add_carry;
  logic             accept;

  acc_adder_ext #(
    .IN_W  (IN_W),
    .ACC_W (ACC_W)
  ) u_acc_adder_ext (
    .acc_i   (acc_q),
    .val_i   ({in_cout, in_sum}),
    .sum_o   (add_sum),
    .carry_o (add_carry)
  );

  // Handshake signals decode the state directly; the total and overflow
  // come straight from registers so they cannot glitch while out_valid is up.
  assign in_ready  = (state_q == ST_ACCUM);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q == ST_ACCUM) || (state_q == ST_DONE);
  assign out_acc   = acc_q;
  assign out_ovf   = ovf_q;
  assign accept    = in_valid && in_ready;

  // Next-state logic. A start is only looked at in IDLE, so a start that
  // coincides with the DONE handshake is dropped rather than queued.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    n_lat_d = n_lat_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          n_lat_d = num_samples;
          acc_d   = '0;
          ovf_d   = 1'b0;
          cnt_d   = '0;
          state_d = (num_samples == CNT_ZERO) ? ST_DONE : ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        if (accept) begin
          acc_d = add_sum;
          ovf_d = ovf_q | add_carry;
          cnt_d = cnt_q + CNT_ONE;
          // n_lat_q is never zero here: a zero-length run skips ACCUM.
          if (cnt_q == (n_lat_q - CNT_ONE)) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // All state lives in one register bank; reset aborts any run immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      n_lat_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      n_lat_q <= n_lat_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule
